au_dec_timer_sched: RTL and testbench
=====================================

Name: au_dec_timer_sched

Overview:
- Time-multiplexed countdown-timer scheduler for CHAN independent channels.
- All channels share one decrementer instance (carry-in/carry-out variant, prefix-AND propagate lookahead, ARCH passed through).
- A round-robin slot pointer gives the decrementer to one channel per enabled cycle.
- The decrementer's borrow-out (co) marks expiry. The block exposes a load handshake, per-channel busy flags, an expiry event stream and a debug count readback.

Parameters:
- WIDTH, 8: counter word length (>= 1).
- CHAN, 4: number of timer channels (>= 2, power of two).
- ARCH, 0: decrementer prefix architecture (0 to 2), passed through unchanged.
- CW (localparam), $clog2(CHAN): channel index width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  global tick enable; advances the slot pointer and performs the visit.
- load_valid  input  1  load request.
- load_ready  output  1  combinational; 1 iff channel load_chan is idle.
- load_chan  input  CW  target channel of the load.
- load_value  input  WIDTH  initial count.
- busy  output  CHAN  registered per-channel active flags.
- expire_valid  output  1  registered one-cycle expiry pulse.
- expire_chan  output  CW  channel that expired; valid only while expire_valid=1.
- rd_chan  input  CW  debug readback select.
- rd_count  output  WIDTH  combinational stored count of channel rd_chan.

Behaviour:
- Reset (async, any time, including mid-countdown): slot pointer sp=0, all counts=0, busy=0, expire_valid=0, expire_chan=0. Pending expiries are discarded.
- State per channel: count[WIDTH], busy bit. Global state: sp[CW].
- Load:
  - Accepted at a rising edge when load_valid & load_ready.
  - On accept: count[load_chan] <= load_value, busy[load_chan] <= 1.
  - A load to a busy channel is not accepted and has no effect.
  - Loads are accepted regardless of enable.
- Visit, in every cycle with enable=1:
  - Decrementer inputs: a=count[sp], ci=busy[sp] & ~(load accepted to channel sp this cycle).
  - If ci=1 and co=0: count[sp] <= z (count minus 1).
  - If ci=1 and co=1 (count was 0, borrow): busy[sp] <= 0, count[sp] <= 0, expire_valid <= 1, expire_chan <= sp.
  - Otherwise expire_valid <= 0.
  - At the same edge, sp <= sp+1, wrapping CHAN-1 -> 0.
- enable=0: sp, counts and busy flags hold (except for loads). expire_valid <= 0.
- Expiry timing:
  - A channel loaded with V expires on its (V+1)th visit.
  - Visits to one channel are CHAN enabled cycles apart.
  - expire_valid rises on the cycle after the expiring visit. busy clears at that same edge.
- Load vs visit collision: if a load is accepted for channel sp in the same cycle, the load wins. No decrement, no expiry that cycle; the first real visit is CHAN enabled cycles later.
- Maximum expiries: one per cycle. Back-to-back pulses on consecutive cycles from different channels are legal.
- A channel freed by expiry may be reloaded from the cycle in which busy=0 is visible.
- Arithmetic: the count wraps never. The borrow path deactivates the channel and the stored count becomes 0, never all-ones.

Test Plan:
- Cycle 0 numbering below has sp=0 in cycle 0, WIDTH=8, CHAN=4, enable=1 unless stated.
- Reset; load ch2 value 0 accepted at cycle 0 -> visit cycle 2 borrows -> expire_valid=1, expire_chan=2 in cycle 3; busy=4'b0000 in cycle 3.
- Load ch1 value 3 at cycle 0 -> rd_count(ch1) reads 3, then 2 after cycle 1, 1 after cycle 5, 0 after cycle 9 -> expire pulse chan 1 in cycle 14, single cycle.
- Ch1 busy, load_chan=1, load_valid=1 -> load_ready=0; count and busy unchanged. Same cycle, load_chan=0 idle -> load_ready=1 and the load is accepted.
- Load ch3 value 0 while sp=3 -> no expire that cycle; first visit cycle 7 -> expire in cycle 8.
- Load ch0=0 and ch1=0 before their slots -> expire pulses in consecutive cycles with chan 0 then chan 1.
- Drop enable for 5 cycles -> sp and counts frozen, expire_valid=0. Assert rst mid-countdown -> busy=0, rd_count=0, sp=0 immediately (async), no later expiry.

Source files
------------

// File: rtl/au_dec_timer_sched.sv
// Round-robin countdown scheduler: CHAN timers share one decrementer, one slot visited per enabled cycle.
// Expiry pulse one cycle after the borrowing visit; loads back-pressure via load_ready while the target is busy.

module au_dec_timer_sched_dec #(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic             ci,
    output logic [WIDTH-1:0] z,
    output logic             co
);
    // brw[i] = ci & (a[i-1:0] == 0): the borrow reaching bit i, built as a prefix AND
    function automatic logic [WIDTH:0] prefix_and(input logic [WIDTH:0] g);
        logic [WIDTH:0] p;
        logic [WIDTH:0] n;
        p = g;
        if (ARCH == 0) begin
            for (int i = 1; i <= WIDTH; i++) p[i] = p[i] & p[i-1];
        end else begin
            for (int k = 0; (1 << k) <= WIDTH; k++) begin
                n = p;
                for (int i = 0; i <= WIDTH; i++) begin
                    if (ARCH == 1) begin
                        if (i >= (1 << k)) n[i] = p[i] & p[i - (1 << k)];
                    end else if (((i >> k) & 1) == 1) begin
                        n[i] = p[i] & p[((i >> k) << k) - 1];
                    end
                end
                p = n;
            end
        end
        return p;
    endfunction

    logic [WIDTH:0] brw;

    assign brw = prefix_and({~a, ci});
    assign z   = a ^ brw[WIDTH-1:0];
    assign co  = brw[WIDTH];
endmodule

module au_dec_timer_sched #(
    parameter int WIDTH = 8,
    parameter int CHAN  = 4,
    parameter int ARCH  = 0,
    localparam int CW   = $clog2(CHAN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [CW-1:0]    load_chan,
    input  logic [WIDTH-1:0] load_value,
    output logic [CHAN-1:0]  busy,
    output logic             expire_valid,
    output logic [CW-1:0]    expire_chan,
    input  logic [CW-1:0]    rd_chan,
    output logic [WIDTH-1:0] rd_count
);
    logic [WIDTH-1:0] count [CHAN];
    logic [CW-1:0]    sp;
    logic             load_acc;
    logic             ci;
    logic             co;
    logic [WIDTH-1:0] z;

    assign load_ready = ~busy[load_chan];
    assign load_acc   = load_valid & load_ready;
    // A load landing on the visited slot wins; that slot is skipped this round.
    assign ci         = busy[sp] & ~(load_acc & (load_chan == sp));
    assign rd_count   = count[rd_chan];

    au_dec_timer_sched_dec #(
        .WIDTH (WIDTH),
        .ARCH  (ARCH)
    ) u_dec (
        .a  (count[sp]),
        .ci (ci),
        .z  (z),
        .co (co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp           <= '0;
            busy         <= '0;
            expire_valid <= 1'b0;
            expire_chan  <= '0;
            for (int i = 0; i < CHAN; i++) count[i] <= '0;
        end else begin
            expire_valid <= 1'b0;
            if (enable) begin
                sp <= sp + 1'b1;
                if (ci) begin
                    if (co) begin
                        busy[sp]     <= 1'b0;
                        count[sp]    <= '0;
                        expire_valid <= 1'b1;
                        expire_chan  <= sp;
                    end else begin
                        count[sp] <= z;
                    end
                end
            end
            if (load_acc) begin
                count[load_chan] <= load_value;
                busy[load_chan]  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_au_dec_timer_sched.sv
// Directed scenarios plus random traffic against a visits-remaining reference model.
module tb_au_dec_timer_sched;
    localparam int WIDTH = 8;
    localparam int CHAN  = 4;
    localparam int CW    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic [CW-1:0]    load_chan = '0;
    logic [WIDTH-1:0] load_value = '0;
    logic [CHAN-1:0]  busy;
    logic             expire_valid;
    logic [CW-1:0]    expire_chan;
    logic [CW-1:0]    rd_chan = '0;
    logic [WIDTH-1:0] rd_count;

    int checks = 0;
    int errors = 0;

    // Model: visits left before expiry (loaded value + 1), per-channel activity,
    // and which channel the next enabled cycle serves.
    int m_rem  [CHAN];
    bit m_busy [CHAN];
    int m_slot;
    bit m_exp;
    int m_expch;

    au_dec_timer_sched #(.WIDTH(WIDTH), .CHAN(CHAN), .ARCH(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_chan    (load_chan),
        .load_value   (load_value),
        .busy         (busy),
        .expire_valid (expire_valid),
        .expire_chan  (expire_chan),
        .rd_chan      (rd_chan),
        .rd_count     (rd_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CHAN; i++) begin
            m_rem[i]  = 0;
            m_busy[i] = 1'b0;
        end
        m_slot  = 0;
        m_exp   = 1'b0;
        m_expch = 0;
    endtask

    task automatic model_edge();
        bit acc;
        int ch;
        acc   = load_valid && !m_busy[load_chan];
        m_exp = 1'b0;
        if (enable) begin
            ch = m_slot;
            if (m_busy[ch] && !(acc && int'(load_chan) == ch)) begin
                m_rem[ch] = m_rem[ch] - 1;
                if (m_rem[ch] == 0) begin
                    m_busy[ch] = 1'b0;
                    m_exp      = 1'b1;
                    m_expch    = ch;
                end
            end
            m_slot = (m_slot + 1) % CHAN;
        end
        if (acc) begin
            m_rem[load_chan]  = int'(load_value) + 1;
            m_busy[load_chan] = 1'b1;
        end
    endtask

    task automatic check_all();
        logic [CHAN-1:0] eb;
        for (int i = 0; i < CHAN; i++) eb[i] = m_busy[i];
        chk("busy", busy, eb);
        chk("expire_valid", expire_valid, m_exp);
        if (m_exp) chk("expire_chan", expire_chan, m_expch);
        chk("rd_count", rd_count, m_busy[rd_chan] ? m_rem[rd_chan] - 1 : 0);
    endtask

    // Inputs are set at a falling edge; one rising edge is consumed per call.
    task automatic step();
        #1;
        chk("load_ready", load_ready, !m_busy[load_chan]);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        load_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic load(input int ch, input int v);
        load_valid = 1'b1;
        load_chan  = CW'(ch);
        load_value = WIDTH'(v);
        step();
        load_valid = 1'b0;
    endtask

    // Reset asserted between edges to exercise the asynchronous path.
    task automatic async_reset();
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst    = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check_all();
        rst    = 1'b0;
        enable = 1'b1;

        // Value 0 on ch2: borrow at its first visit (cycle 2), pulse in cycle 3.
        load(2, 0);
        idle(2);
        chk("a_exp_valid", expire_valid, 1);
        chk("a_exp_chan", expire_chan, 2);
        chk("a_busy", busy, 0);
        idle(1);
        chk("a_exp_gone", expire_valid, 0);

        // Value 3 on ch1: four visits, pulse in cycle 14; busy refusal then idle accept.
        async_reset();
        rd_chan = 1;
        load(1, 3);
        chk("b_rd_load", rd_count, 3);
        idle(1);
        chk("b_rd_dec", rd_count, 2);
        load_valid = 1'b1;
        load_chan  = 1;
        load_value = 77;
        #1 chk("b_ready_busy", load_ready, 0);
        step();
        chk("b_rd_unchanged", rd_count, 2);
        load_chan  = 0;
        load_value = 20;
        #1 chk("b_ready_idle", load_ready, 1);
        step();
        load_valid = 1'b0;
        chk("b_busy_both", busy, 4'b0011);
        idle(10);
        chk("b_exp_valid", expire_valid, 1);
        chk("b_exp_chan", expire_chan, 1);
        chk("b_rd_zero", rd_count, 0);
        idle(1);
        chk("b_single_pulse", expire_valid, 0);

        // Load lands on the slot being visited: first real visit one round later.
        async_reset();
        idle(3);
        load(3, 0);
        chk("d_no_exp", expire_valid, 0);
        idle(4);
        chk("d_exp_valid", expire_valid, 1);
        chk("d_exp_chan", expire_chan, 3);

        // Back-to-back pulses from adjacent channels.
        async_reset();
        load(0, 0);
        load(1, 0);
        idle(3);
        chk("e_exp0_valid", expire_valid, 1);
        chk("e_exp0_chan", expire_chan, 0);
        idle(1);
        chk("e_exp1_valid", expire_valid, 1);
        chk("e_exp1_chan", expire_chan, 1);

        // Enable dropped: everything frozen; then reset mid-countdown.
        async_reset();
        rd_chan = 2;
        load(2, 5);
        idle(2);
        chk("f_rd_before", rd_count, 4);
        enable = 1'b0;
        idle(5);
        chk("f_rd_frozen", rd_count, 4);
        enable = 1'b1;
        idle(3);
        chk("f_rd_resume", rd_count, 4);
        async_reset();
        chk("f_rd_reset", rd_count, 0);
        idle(40);

        // Random traffic against the model, with one asynchronous reset mid-run.
        for (int i = 0; i < 800; i++) begin
            if (i == 400) async_reset();
            enable     = ($urandom_range(0, 9) < 8);
            load_valid = ($urandom_range(0, 2) == 0);
            load_chan  = CW'($urandom_range(0, CHAN - 1));
            load_value = WIDTH'($urandom_range(0, 9));
            rd_chan    = CW'($urandom_range(0, CHAN - 1));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
